// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and decode hand-off.
// master = fetch unit, slave = the memory/decode/execute side that surrounds it.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc4;
   logic        misaligned;
   logic [31:0] fetch_count;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
             misaligned, fetch_count,
      input  imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
             misaligned, fetch_count,
      output imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch FSM: one word per 2 cycles at best, memory wait states stall in REQ, decode stall holds HOLD.
// Redirect wins over everything; a request already on the bus is drained in FLUSH and its data dropped.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic          i_clk,
   input  logic          i_reset,
   instr_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_req;
   logic [31:0] r_addr;
   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic [31:0] r_instr_pc4;
   logic        r_misaligned;
   logic [31:0] r_fetch_count;

   logic [31:0] w_tgt;
   logic        w_tgt_mis;

   assign w_tgt     = {bus.redirect_pc[31:2], 2'b00};
   assign w_tgt_mis = |bus.redirect_pc[1:0];

   assign bus.imem_req    = r_req;
   assign bus.imem_addr   = r_addr;
   assign bus.instr_valid = r_valid;
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instr_pc;
   assign bus.instr_pc4   = r_instr_pc4;
   assign bus.misaligned  = r_misaligned;
   assign bus.fetch_count = r_fetch_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_req         <= 1'b0;
         r_addr        <= RESET_PC;
         r_valid       <= 1'b0;
         r_instr       <= NOP_INSTR;
         r_instr_pc    <= 32'h0;
         r_instr_pc4   <= 32'h0;
         r_misaligned  <= 1'b0;
         r_fetch_count <= 32'h0;
      end else begin
         if (bus.redirect) begin
            r_pc <= w_tgt;
            if (w_tgt_mis) r_misaligned <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               // Any memory response seen here belongs to a pre-reset request.
               r_state <= REQ;
               r_req   <= 1'b1;
               r_addr  <= bus.redirect ? w_tgt : r_pc;
            end
            REQ: begin
               if (bus.redirect) begin
                  if (bus.imem_rvalid) r_addr <= w_tgt;
                  else                 r_state <= FLUSH;
               end else if (bus.imem_rvalid) begin
                  r_instr     <= bus.imem_rdata;
                  r_instr_pc  <= r_pc;
                  r_instr_pc4 <= r_pc + 32'd4;
                  r_pc        <= r_pc + 32'd4;
                  r_req       <= 1'b0;
                  r_valid     <= 1'b1;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (bus.redirect) begin
                  r_valid <= 1'b0;
                  r_instr <= NOP_INSTR;
                  r_req   <= 1'b1;
                  r_addr  <= w_tgt;
                  r_state <= REQ;
               end else if (bus.instr_ready) begin
                  r_fetch_count <= r_fetch_count + 32'd1;
                  r_valid       <= 1'b0;
                  r_instr       <= NOP_INSTR;
                  r_req         <= 1'b1;
                  r_addr        <= r_pc;
                  r_state       <= REQ;
               end
            end
            FLUSH: begin
               // Address stays on the stale request until memory answers it.
               if (!bus.redirect && bus.imem_rvalid) begin
                  r_addr  <= r_pc;
                  r_state <= REQ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: dut_a uses RESET_PC=0, dut_b checks PC wrap and async reset mid-wait.
module tb_instr_fetch;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic auto_rv = 1'b1;
   logic man_rv = 1'b0;
   logic rv_b = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   instr_fetch_if ifa();
   instr_fetch_if ifb();

   assign ifa.imem_rvalid = auto_rv ? ifa.imem_req : man_rv;
   assign ifa.imem_rdata  = ifa.imem_addr ^ 32'hDEAD_0000;
   assign ifb.imem_rvalid = rv_b;
   assign ifb.imem_rdata  = ifb.imem_addr ^ 32'hDEAD_0000;

   instr_fetch dut_a (.i_clk(clk), .i_reset(rst_a), .bus(ifa.master));
   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.i_clk(clk), .i_reset(rst_b), .bus(ifb.master));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      ifa.redirect = 1'b0;
      ifa.redirect_pc = 32'h0;
      ifa.instr_ready = 1'b1;
      ifb.redirect = 1'b0;
      ifb.redirect_pc = 32'h0;
      ifb.instr_ready = 1'b1;

      // reset state
      tick();
      check("rst_req",   32'(ifa.imem_req), 32'h0);
      check("rst_vld",   32'(ifa.instr_valid), 32'h0);
      check("rst_instr", ifa.instr, 32'h0000_0013);
      check("rst_pc",    ifa.instr_pc, 32'h0);
      check("rst_pc4",   ifa.instr_pc4, 32'h0);
      check("rst_mis",   32'(ifa.misaligned), 32'h0);
      check("rst_cnt",   ifa.fetch_count, 32'h0);
      rst_a = 1'b0;

      // zero-wait streaming: REQ / HOLD alternate
      for (int k = 0; k < 2; k++) begin
         tick();
         check("t1_req",  32'(ifa.imem_req), 32'h1);
         check("t1_addr", ifa.imem_addr, 32'(4 * k));
         check("t1_vlo",  32'(ifa.instr_valid), 32'h0);
         tick();
         check("t1_vhi",  32'(ifa.instr_valid), 32'h1);
         check("t1_ipc",  ifa.instr_pc, 32'(4 * k));
         check("t1_ins",  ifa.instr, 32'hDEAD_0000 ^ 32'(4 * k));
         check("t1_pc4",  ifa.instr_pc4, 32'(4 * k + 4));
      end

      // three wait states at 0x8
      auto_rv = 1'b0;
      man_rv = 1'b0;
      for (int w = 0; w < 4; w++) begin
         tick();
         check("t2_addr", ifa.imem_addr, 32'h8);
         check("t2_req",  32'(ifa.imem_req), 32'h1);
      end
      check("t2_cnt", ifa.fetch_count, 32'h2);
      man_rv = 1'b1;
      ifa.instr_ready = 1'b0;
      tick();
      man_rv = 1'b0;
      check("t2_ins", ifa.instr, 32'hDEAD_0008);
      check("t2_ipc", ifa.instr_pc, 32'h8);
      check("t2_pc4", ifa.instr_pc4, 32'hC);

      // decode stall: outputs frozen
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_vld", 32'(ifa.instr_valid), 32'h1);
         check("t3_ipc", ifa.instr_pc, 32'h8);
         check("t3_ins", ifa.instr, 32'hDEAD_0008);
         check("t3_cnt", ifa.fetch_count, 32'h2);
      end
      ifa.instr_ready = 1'b1;
      tick();
      check("t3_cnt3", ifa.fetch_count, 32'h3);
      check("t3_addr", ifa.imem_addr, 32'hC);
      check("t3_vlo",  32'(ifa.instr_valid), 32'h0);

      // redirect while REQ waits on 0x10
      man_rv = 1'b1;
      tick();
      check("t4_ipcC", ifa.instr_pc, 32'hC);
      man_rv = 1'b0;
      tick();
      check("t4_a10", ifa.imem_addr, 32'h10);
      check("t4_cnt", ifa.fetch_count, 32'h4);
      ifa.redirect = 1'b1;
      ifa.redirect_pc = 32'h100;
      tick();
      ifa.redirect = 1'b0;
      check("t4_fl_addr", ifa.imem_addr, 32'h10);
      check("t4_fl_req",  32'(ifa.imem_req), 32'h1);
      tick();
      check("t4_fl_addr2", ifa.imem_addr, 32'h10);
      man_rv = 1'b1;
      tick();
      man_rv = 1'b0;
      check("t4_a100", ifa.imem_addr, 32'h100);
      check("t4_req",  32'(ifa.imem_req), 32'h1);
      check("t4_vlo",  32'(ifa.instr_valid), 32'h0);
      tick();
      check("t4_vlo2", 32'(ifa.instr_valid), 32'h0);
      man_rv = 1'b1;
      tick();
      man_rv = 1'b0;
      check("t4_ipc", ifa.instr_pc, 32'h100);
      check("t4_ins", ifa.instr, 32'hDEAD_0100);

      // redirect in HOLD with ready=1, misaligned target
      ifa.redirect = 1'b1;
      ifa.redirect_pc = 32'h202;
      tick();
      ifa.redirect = 1'b0;
      check("t5_vlo",  32'(ifa.instr_valid), 32'h0);
      check("t5_cnt",  ifa.fetch_count, 32'h4);
      check("t5_addr", ifa.imem_addr, 32'h200);
      check("t5_mis",  32'(ifa.misaligned), 32'h1);
      check("t5_nop",  ifa.instr, 32'h0000_0013);

      // redirect coinciding with rvalid in REQ
      man_rv = 1'b1;
      ifa.redirect = 1'b1;
      ifa.redirect_pc = 32'h40;
      tick();
      ifa.redirect = 1'b0;
      man_rv = 1'b0;
      check("t5b_addr", ifa.imem_addr, 32'h40);
      check("t5b_vlo",  32'(ifa.instr_valid), 32'h0);
      check("t5b_mis",  32'(ifa.misaligned), 32'h1);

      // PC wrap on dut_b
      rst_b = 1'b0;
      tick();
      check("t6_a0", ifb.imem_addr, 32'hFFFF_FFFC);
      rv_b = 1'b1;
      tick();
      rv_b = 1'b0;
      check("t6_ipc", ifb.instr_pc, 32'hFFFF_FFFC);
      check("t6_pc4", ifb.instr_pc4, 32'h0);
      tick();
      check("t6_a1",  ifb.imem_addr, 32'h0);
      check("t6_cnt", ifb.fetch_count, 32'h1);
      tick();
      check("t6_req", 32'(ifb.imem_req), 32'h1);

      // async reset between clock edges
      #3 rst_b = 1'b1;
      #1;
      check("t6_ar_req", 32'(ifb.imem_req), 32'h0);
      check("t6_ar_cnt", ifb.fetch_count, 32'h0);
      check("t6_ar_ipc", ifb.instr_pc, 32'h0);
      check("t6_ar_pc4", ifb.instr_pc4, 32'h0);
      check("t6_ar_vld", 32'(ifb.instr_valid), 32'h0);

      // stale response while IDLE is ignored
      rv_b = 1'b1;
      tick();
      rst_b = 1'b0;
      tick();
      rv_b = 1'b0;
      check("t6_idle_vld",  32'(ifb.instr_valid), 32'h0);
      check("t6_idle_addr", ifb.imem_addr, 32'hFFFF_FFFC);
      check("t6_idle_req",  32'(ifb.imem_req), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
